// File: rtl/cpu_pkg.sv
// Shared definitions for the EX-stage iterative multiplier: RV32M multiply op
// encoding, default datapath geometry and the multiplier FSM state encoding.
package cpu_pkg;

  // Default datapath geometry
  localparam int DATA_W_DEF  = 32;
  localparam int CHUNK_W_DEF = 8;

  // RV32M multiply op encoding as decoded into the ID/EX register
  typedef logic [1:0] mul_op_t;
  localparam mul_op_t OP_MUL    = 2'b00;
  localparam mul_op_t OP_MULH   = 2'b01;
  localparam mul_op_t OP_MULHSU = 2'b10;
  localparam mul_op_t OP_MULHU  = 2'b11;

  // Multiplier FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Operand a is signed for MULH and MULHSU
  function automatic logic op_a_signed(input mul_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  // Operand b is signed only for MULH
  function automatic logic op_b_signed(input mul_op_t op);
    return (op == OP_MULH);
  endfunction

endpackage

// File: rtl/mult_chunk_pp.sv
// Partial-product generator: |a| times one CHUNK_W-bit slice of |b|, shifted
// into its position within the 2*DATA_W-bit product. Purely combinational.
module mult_chunk_pp
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int CNT_W   = 2
) (
  input  logic [DATA_W-1:0]   a_mag,
  input  logic [CHUNK_W-1:0]  chunk,
  input  logic [CNT_W-1:0]    cnt,
  output logic [2*DATA_W-1:0] pp
);

  logic [2*DATA_W-1:0] a_ext_s;
  logic [2*DATA_W-1:0] c_ext_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [31:0]         sh_s;

  // Zero-extend both factors so the product cannot wrap, then place it at chunk cnt
  always_comb begin
    a_ext_s = {{DATA_W{1'b0}}, a_mag};
    c_ext_s = {{(2*DATA_W-CHUNK_W){1'b0}}, chunk};
    prod_s  = a_ext_s * c_ext_s;
    sh_s    = 32'(cnt) * 32'(CHUNK_W);
    pp      = prod_s << sh_s;
  end

endmodule

// File: rtl/ex_iterative_multiplier.sv
// EX-stage multi-cycle multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Works on operand magnitudes, consuming CHUNK_W bits of |b| per cycle, and
// applies the result sign once at the end. stall is combinational so the
// pipeline freezes in the accept cycle itself.
// Optional build macro: MULT_EARLY_OUT_EN -- finish as soon as the remaining
// upper chunks of |b| are all zero (variable latency).
module ex_iterative_multiplier
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              flush,
  output logic              stall,
  output logic              result_valid,
  output logic [DATA_W-1:0] result
);

  localparam int N     = DATA_W / CHUNK_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [DATA_W-1:0] ONE_W = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [1:0]          state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                sign_q, sign_d;
  logic [1:0]          op_q, op_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                valid_q, valid_d;

  logic                stall_s;
  logic                a_neg_s, b_neg_s;
  logic [DATA_W-1:0]   a_mag_s, b_mag_s;
  logic [CHUNK_W-1:0]  chunk_s;
  logic [2*DATA_W-1:0] pp_s;
  logic [2*DATA_W-1:0] final_s;
`ifdef MULT_EARLY_OUT_EN
  logic [31:0]         sh_next_s;
  logic                rem_zero_s;
`endif

  // Magnitudes of the incoming operands; -2^(DATA_W-1) maps to 2^(DATA_W-1) unsigned
  always_comb begin
    a_neg_s = op_a_signed(op) & operand_a[DATA_W-1];
    b_neg_s = op_b_signed(op) & operand_b[DATA_W-1];
    if (a_neg_s) begin
      a_mag_s = ~operand_a + ONE_W;
    end else begin
      a_mag_s = operand_a;
    end
    if (b_neg_s) begin
      b_mag_s = ~operand_b + ONE_W;
    end else begin
      b_mag_s = operand_b;
    end
  end

  // Select the chunk of |b| addressed by the iteration counter
  always_comb begin
    chunk_s = {CHUNK_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        chunk_s = b_q[i*CHUNK_W +: CHUNK_W];
      end else begin
        chunk_s = chunk_s;
      end
    end
  end

`ifdef MULT_EARLY_OUT_EN
  // True when every chunk above the one just consumed is zero
  always_comb begin
    sh_next_s  = (32'(cnt_q) + 32'd1) * 32'(CHUNK_W);
    rem_zero_s = ((b_q >> sh_next_s) == {DATA_W{1'b0}});
  end
`endif

  mult_chunk_pp #(
    .DATA_W  (DATA_W),
    .CHUNK_W (CHUNK_W),
    .CNT_W   (CNT_W)
  ) u_pp (
    .a_mag (a_q),
    .chunk (chunk_s),
    .cnt   (cnt_q),
    .pp    (pp_s)
  );

  // FSM next state, accumulation and result formation
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = 1'b0;
    stall_s  = 1'b0;
    final_s  = {(2*DATA_W){1'b0}};

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            stall_s = 1'b1;
            a_d     = a_mag_s;
            b_d     = b_mag_s;
            sign_d  = a_neg_s ^ b_neg_s;
            op_d    = op;
            acc_d   = {(2*DATA_W){1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_BUSY;
`ifdef MULT_EARLY_OUT_EN
            if (b_mag_s == {DATA_W{1'b0}}) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_BUSY;
            end
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          stall_s = 1'b1;
          acc_d   = acc_q + pp_s;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_W'(N-1)) begin
            state_d = ST_DONE;
`ifdef MULT_EARLY_OUT_EN
          end else if (rem_zero_s) begin
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_DONE: begin
          // Same instruction still sits in EX here, so start is ignored
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Result is captured on entry to DONE so it is registered in that cycle
    if (state_d == ST_DONE) begin
      valid_d = 1'b1;
      if (sign_d) begin
        final_s = {(2*DATA_W){1'b0}} - acc_d;
      end else begin
        final_s = acc_d;
      end
      if (op_d == OP_MUL) begin
        result_d = final_s[DATA_W-1:0];
      end else begin
        result_d = final_s[2*DATA_W-1:DATA_W];
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= {DATA_W{1'b0}};
      b_q      <= {DATA_W{1'b0}};
      sign_q   <= 1'b0;
      op_q     <= OP_MUL;
      acc_q    <= {(2*DATA_W){1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      result_q <= {DATA_W{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // A flush arriving in DONE kills the instruction, so its valid pulse is dropped
  assign stall        = stall_s;
  assign result_valid = valid_q & ~flush;
  assign result       = result_q;

endmodule

// File: doc/ex_iterative_multiplier.md
Name: ex_iterative_multiplier

Overview:
- EX-stage multi-cycle multiplier for the RV32M MUL/MULH/MULHSU/MULHU ops; processes 8 bits of the multiplier operand per cycle, 4 iterations.
- Consumes operands and the decoded op from the ID/EX register, downstream of the load-use hazard logic.
- Raises a stall that the top level ORs into the pipeline freeze (PC, IF/ID, ID/EX write enables low) until the result is ready.
- Supplies the result to the EX result mux.

Parameters:
- DATA_W, 32, operand width; must be a multiple of CHUNK_W.
- CHUNK_W, 8, multiplier bits consumed per iteration; iterations N = DATA_W/CHUNK_W = 4.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- start  input  1  EX holds a valid multiply op; stays high while the pipeline is frozen
- op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- operand_a  input  DATA_W  rs1 value (post-forwarding)
- operand_b  input  DATA_W  rs2 value (post-forwarding)
- flush  input  1  EX instruction killed (branch redirect)
- stall  output  1  freeze request to the pipeline
- result_valid  output  1  result is valid this cycle
- result  output  DATA_W  MUL → low word of the product; other ops → high word

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; accumulator, counter and result all zero; result_valid=0; stall=0.
  - Reset overrides everything, including an operation in flight.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall = start & ~flush, combinational, so the freeze takes effect in the accept cycle T.
  - On start & ~flush: latch |a| and |b| (signedness per op), sign_res, op; clear the 2*DATA_W accumulator; cnt=0; go to BUSY.
- Signedness per op:
  - MUL and MULHU treat both operands as unsigned.
  - MULH treats both as signed.
  - MULHSU treats a as signed and b as unsigned.
- BUSY:
  - stall=1.
  - Each cycle: acc += |a| * b_chunk[cnt] << (cnt*CHUNK_W); cnt++.
  - After iteration N-1, go to DONE.
  - With N=4, BUSY covers cycles T+1..T+4.
- DONE (cycle T+5):
  - stall=0; result_valid=1.
  - result = selected half of (sign_res ? −acc : acc), registered.
  - The pipeline advances at the end of this cycle.
  - start is ignored in DONE (the same instruction is still in EX); next state is IDLE unconditionally.
- result holds its last value until the next DONE; result_valid is a 1-cycle pulse.
- Total freeze is N+1 cycles (T..T+4); latency from accept to result is N+1 cycles.
- flush:
  - In any state, flush=1 → next state IDLE, stall=0 in that cycle, result_valid=0, result unchanged.
  - flush has priority over start.
- Arithmetic and width rules:
  - Accumulator is 2*DATA_W bits; no overflow is possible.
  - Negation is two's complement over 2*DATA_W bits.
  - |−2^31| = 2^31 must be handled in unsigned form, with no truncation.
- Operands are sampled only at accept; later changes on operand_a/operand_b have no effect.

Optional Feature:
- Macro: MULT_EARLY_OUT_EN.
- Defined:
  - At accept, and in BUSY after each iteration, if all remaining higher chunks of |b| are zero, go to DONE next.
  - Example: b=5 gives one BUSY cycle, freeze of 2 cycles.
  - b=0 at accept goes straight to DONE (freeze of 1 cycle).
- Undefined: always N iterations, fixed latency.

Decomposition:
- Shared package (cpu_pkg):
  - MUL op encoding localparams (OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU).
  - Default DATA_W and CHUNK_W.
  - FSM state encoding.
- Sub-module mult_chunk_pp: combinational |a| × CHUNK_W-bit chunk, shifted partial product. Instantiated once; chunk select is by cnt.

Test Plan:
- MUL a=7, b=6, start held → stall high for 5 cycles, then result_valid=1 with result=0x0000002A; stall=0 in that cycle.
- MULHU a=b=0xFFFFFFFF → result=0xFFFFFFFE. MUL on the same operands → 0x00000001.
- MULH a=0x80000000, b=0x80000000 → result=0x40000000. MULHSU a=0xFFFFFFFE (−2), b=3 → result=0xFFFFFFFF.
- Flush at T+2 with start high → stall=0 that cycle, IDLE next cycle, no result_valid. A fresh start at T+4 completes normally with a correct result.
- rst=1 at T+3 → next cycle state IDLE, stall=0, result=0, result_valid=0.
- With MULT_EARLY_OUT_EN: b=5 → freeze of 2 cycles; b=0 → freeze of 1 cycle with result 0. Without the macro: freeze is always 5 cycles.
